// File: rtl/mem_access_master.sv
// mem_access_master
//   Initiator side of the unified single-port instruction/data memory of the multicycle core.
//   Arbitrates fetch vs. load/store requests (load/store wins), rejects misaligned or
//   out-of-range addresses, maps byte addresses to the memory's 9-bit word address
//   (bit 8 = data region, bits 7:0 = word index) and runs one 1-cycle access at a time.
// Ports
//   i_clk, i_rst                 clock (rising edge), asynchronous active-high reset
//   i_if_req, i_pc               fetch request and byte address
//   i_ls_req, i_ls_we,
//   i_ls_addr, i_ls_wdata        load/store request, 1=store, byte address, store data
//   o_ready                      high in idle; requests are sampled only then
//   o_instr, o_instr_valid       last fetched instruction and its update pulse
//   o_ldata, o_ld_valid          last load data and its update pulse
//   o_st_done                    pulse after a store has been written
//   o_err                        pulse after a request was rejected
//   o_fetch_cnt, o_data_cnt      completed fetches / loads+stores, wrapping
//   o_mem_addr, o_mem_we,
//   o_mem_wdata, i_mem_rdata     memory side (combinational read)
module mem_access_master #(
    parameter int unsigned DEPTH_INST = 256,
    parameter int unsigned DEPTH_DATA = 256,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_if_req,
    input  logic [31:0]      i_pc,
    input  logic             i_ls_req,
    input  logic             i_ls_we,
    input  logic [31:0]      i_ls_addr,
    input  logic [31:0]      i_ls_wdata,
    output logic             o_ready,
    output logic [31:0]      o_instr,
    output logic             o_instr_valid,
    output logic [31:0]      o_ldata,
    output logic             o_ld_valid,
    output logic             o_st_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_fetch_cnt,
    output logic [CNT_W-1:0] o_data_cnt,
    output logic [31:0]      o_mem_addr,
    output logic             o_mem_we,
    output logic [31:0]      o_mem_wdata,
    input  logic [31:0]      i_mem_rdata
);

    localparam logic [31:0] InstLimit = 32'(DEPTH_INST * 4);
    localparam logic [31:0] DataLimit = 32'(DEPTH_DATA * 4);

    typedef enum logic [1:0] {StIdle, StFetch, StLoad, StStore} state_e;

    state_e           state_q, state_d;
    logic [8:0]       mem_addr_q, mem_addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_d;
    logic             err_q;
    logic [31:0]      instr_q, ldata_q;
    logic             instr_valid_q, ld_valid_q, st_done_q;
    logic [CNT_W-1:0] fetch_cnt_q, data_cnt_q;
    logic             ls_bad, if_bad;

    assign ls_bad = (i_ls_addr[1:0] != 2'b00) || (i_ls_addr >= DataLimit);
    assign if_bad = (i_pc[1:0] != 2'b00) || (i_pc >= InstLimit);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Load/store wins; a losing fetch is simply not sampled this edge.
                if (i_ls_req) begin
                    if (ls_bad) begin
                        err_d = 1'b1;
                    end else begin
                        mem_addr_d = {1'b1, i_ls_addr[9:2]};
                        wdata_d    = i_ls_wdata;
                        state_d    = i_ls_we ? StStore : StLoad;
                    end
                end else if (i_if_req) begin
                    if (if_bad) begin
                        err_d = 1'b1;
                    end else begin
                        mem_addr_d = {1'b0, i_pc[9:2]};
                        state_d    = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            mem_addr_q    <= '0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            instr_q       <= '0;
            ldata_q       <= '0;
            instr_valid_q <= 1'b0;
            ld_valid_q    <= 1'b0;
            st_done_q     <= 1'b0;
            fetch_cnt_q   <= '0;
            data_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            instr_valid_q <= (state_q == StFetch);
            ld_valid_q    <= (state_q == StLoad);
            st_done_q     <= (state_q == StStore);
            if (state_q == StFetch) begin
                instr_q     <= i_mem_rdata;
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            end
            if (state_q == StLoad) begin
                ldata_q <= i_mem_rdata;
            end
            if (state_q == StLoad || state_q == StStore) begin
                data_cnt_q <= data_cnt_q + CNT_W'(1);
            end
        end
    end

    // Write enable is decoded from state so it drops as soon as reset asserts.
    assign o_mem_we      = (state_q == StStore);
    assign o_mem_wdata   = o_mem_we ? wdata_q : 32'h0;
    assign o_mem_addr    = {23'b0, mem_addr_q};
    assign o_ready       = (state_q == StIdle);
    assign o_instr       = instr_q;
    assign o_instr_valid = instr_valid_q;
    assign o_ldata       = ldata_q;
    assign o_ld_valid    = ld_valid_q;
    assign o_st_done     = st_done_q;
    assign o_err         = err_q;
    assign o_fetch_cnt   = fetch_cnt_q;
    assign o_data_cnt    = data_cnt_q;

endmodule

// File: tb/tb_mem_access_master.sv
module tb_mem_access_master;

    logic        i_clk;
    logic        i_rst;
    logic        i_if_req, i_ls_req, i_ls_we;
    logic [31:0] i_pc, i_ls_addr, i_ls_wdata;
    logic        o_ready, o_instr_valid, o_ld_valid, o_st_done, o_err, o_mem_we;
    logic [31:0] o_instr, o_ldata, o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [15:0] o_fetch_cnt, o_data_cnt;

    // Second instance with a narrow counter so the wrap is reachable quickly.
    logic        if_req2;
    logic [31:0] pc2;
    logic        zero1;
    logic [31:0] zero32;
    logic        ready2, instr_valid2, ld_valid2, st_done2, err2, mem_we2;
    logic [31:0] instr2, ldata2, mem_addr2, mem_wdata2, mem_rdata2;
    logic [7:0]  fetch_cnt2, data_cnt2;

    int errors = 0;
    int checks = 0;

    // Memory model: unwritten words read as a fixed region-tagged pattern.
    logic [31:0] wr_mem [512];
    logic [511:0] written;

    function automatic logic [31:0] init_word(input logic [8:0] a);
        return (a[8] ? 32'h2000_0000 : 32'h1000_0000) | {24'h0, a[7:0]};
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            written <= '0;
        end else if (o_mem_we) begin
            written[o_mem_addr[8:0]] <= 1'b1;
            wr_mem[o_mem_addr[8:0]]  <= o_mem_wdata;
        end
    end

    assign i_mem_rdata = written[o_mem_addr[8:0]] ? wr_mem[o_mem_addr[8:0]]
                                                  : init_word(o_mem_addr[8:0]);
    assign mem_rdata2  = init_word(mem_addr2[8:0]);

    mem_access_master dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_if_req(i_if_req), .i_pc(i_pc),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr), .i_ls_wdata(i_ls_wdata),
        .o_ready(o_ready), .o_instr(o_instr), .o_instr_valid(o_instr_valid),
        .o_ldata(o_ldata), .o_ld_valid(o_ld_valid), .o_st_done(o_st_done), .o_err(o_err),
        .o_fetch_cnt(o_fetch_cnt), .o_data_cnt(o_data_cnt), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    mem_access_master #(.CNT_W(8)) dut_w (
        .i_clk(i_clk), .i_rst(i_rst), .i_if_req(if_req2), .i_pc(pc2),
        .i_ls_req(zero1), .i_ls_we(zero1), .i_ls_addr(zero32), .i_ls_wdata(zero32),
        .o_ready(ready2), .o_instr(instr2), .o_instr_valid(instr_valid2),
        .o_ldata(ldata2), .o_ld_valid(ld_valid2), .o_st_done(st_done2), .o_err(err2),
        .o_fetch_cnt(fetch_cnt2), .o_data_cnt(data_cnt2), .o_mem_addr(mem_addr2),
        .o_mem_we(mem_we2), .o_mem_wdata(mem_wdata2), .i_mem_rdata(mem_rdata2)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_if_req = 0; i_ls_req = 0; i_ls_we = 0;
        i_pc = 0; i_ls_addr = 0; i_ls_wdata = 0; if_req2 = 0; pc2 = 0; zero1 = 0; zero32 = 0;
        repeat (2) step();
        i_rst = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", o_ready); end
        checks++; if (o_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", o_instr); end
        checks++; if (o_ldata !== 32'h0) begin errors++; $display("FAIL rst_ldata got %h want 0", o_ldata); end
        checks++; if (o_fetch_cnt !== 16'd0 || o_data_cnt !== 16'd0) begin errors++;
            $display("FAIL rst_cnt got %0d/%0d want 0/0", o_fetch_cnt, o_data_cnt); end
        checks++; if ({o_mem_we, o_err, o_instr_valid, o_ld_valid, o_st_done} !== 5'b0) begin errors++;
            $display("FAIL rst_pulses got %b want 00000",
                     {o_mem_we, o_err, o_instr_valid, o_ld_valid, o_st_done}); end
        checks++; if (o_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", o_mem_addr); end
    endtask

    task automatic test_fetch();
        i_if_req = 1; i_pc = 32'h8;
        step();
        i_if_req = 0;
        checks++; if (o_mem_addr !== 32'h002 || o_ready !== 1'b0 || o_mem_we !== 1'b0) begin errors++;
            $display("FAIL fetch_access got addr=%h rdy=%b we=%b want 002/0/0", o_mem_addr, o_ready, o_mem_we); end
        step();
        checks++; if (o_instr !== 32'h1000_0002 || o_instr_valid !== 1'b1) begin errors++;
            $display("FAIL fetch_data got %h v=%b want 10000002 v=1", o_instr, o_instr_valid); end
        checks++; if (o_fetch_cnt !== 16'd1 || o_ready !== 1'b1) begin errors++;
            $display("FAIL fetch_cnt got %0d rdy=%b want 1 rdy=1", o_fetch_cnt, o_ready); end
        step();
        checks++; if (o_instr_valid !== 1'b0 || o_instr !== 32'h1000_0002) begin errors++;
            $display("FAIL fetch_hold got %h v=%b want 10000002 v=0", o_instr, o_instr_valid); end
    endtask

    task automatic test_store_load();
        i_ls_req = 1; i_ls_we = 1; i_ls_addr = 32'h10; i_ls_wdata = 32'hDEAD_BEEF;
        step();
        i_ls_req = 0;
        checks++; if (o_mem_we !== 1'b1 || o_mem_addr !== 32'h104 || o_mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL store_access got we=%b addr=%h wd=%h want 1/104/deadbeef",
                               o_mem_we, o_mem_addr, o_mem_wdata); end
        step();
        checks++; if (o_mem_we !== 1'b0 || o_st_done !== 1'b1 || o_data_cnt !== 16'd1) begin errors++;
            $display("FAIL store_done got we=%b done=%b cnt=%0d want 0/1/1", o_mem_we, o_st_done, o_data_cnt); end
        i_ls_req = 1; i_ls_we = 0;
        step();
        i_ls_req = 0;
        checks++; if (o_mem_we !== 1'b0 || o_mem_addr !== 32'h104 || o_st_done !== 1'b0) begin errors++;
            $display("FAIL load_access got we=%b addr=%h done=%b want 0/104/0", o_mem_we, o_mem_addr, o_st_done); end
        step();
        checks++; if (o_ldata !== 32'hDEAD_BEEF || o_ld_valid !== 1'b1 || o_data_cnt !== 16'd2) begin errors++;
            $display("FAIL load_data got %h v=%b cnt=%0d want deadbeef/1/2", o_ldata, o_ld_valid, o_data_cnt); end
    endtask

    task automatic test_priority();
        i_if_req = 1; i_pc = 32'h4; i_ls_req = 1; i_ls_we = 0; i_ls_addr = 32'h0;
        step();
        i_ls_req = 0;
        checks++; if (o_mem_addr !== 32'h100) begin errors++;
            $display("FAIL prio_load_first got addr=%h want 100", o_mem_addr); end
        step();
        checks++; if (o_ldata !== 32'h2000_0000 || o_ld_valid !== 1'b1 || o_instr_valid !== 1'b0) begin
            errors++; $display("FAIL prio_load_data got %h v=%b iv=%b want 20000000/1/0",
                               o_ldata, o_ld_valid, o_instr_valid); end
        step();
        i_if_req = 0;
        checks++; if (o_mem_addr !== 32'h001) begin errors++;
            $display("FAIL prio_fetch_addr got %h want 001", o_mem_addr); end
        step();
        checks++; if (o_instr !== 32'h1000_0001 || o_instr_valid !== 1'b1) begin errors++;
            $display("FAIL prio_fetch_data got %h v=%b want 10000001/1", o_instr, o_instr_valid); end
        checks++; if (o_fetch_cnt !== 16'd2 || o_data_cnt !== 16'd3) begin errors++;
            $display("FAIL prio_cnt got %0d/%0d want 2/3", o_fetch_cnt, o_data_cnt); end
    endtask

    task automatic test_reject();
        logic [31:0] addrs [3];
        logic        is_ls [3];
        addrs[0] = 32'h13;  is_ls[0] = 1;
        addrs[1] = 32'h400; is_ls[1] = 0;
        addrs[2] = 32'h400; is_ls[2] = 1;
        for (int k = 0; k < 3; k++) begin
            i_ls_req = is_ls[k]; i_ls_we = 0; i_ls_addr = addrs[k];
            i_if_req = !is_ls[k]; i_pc = addrs[k];
            step();
            i_ls_req = 0; i_if_req = 0;
            checks++; if (o_err !== 1'b1 || o_ready !== 1'b1 || o_mem_we !== 1'b0 ||
                          o_mem_addr !== 32'h001) begin errors++;
                $display("FAIL reject_%0d got err=%b rdy=%b we=%b addr=%h want 1/1/0/001",
                         k, o_err, o_ready, o_mem_we, o_mem_addr); end
            step();
            checks++; if (o_err !== 1'b0 || o_ld_valid !== 1'b0 || o_instr_valid !== 1'b0) begin errors++;
                $display("FAIL reject_after_%0d got err=%b lv=%b iv=%b want 0/0/0",
                         k, o_err, o_ld_valid, o_instr_valid); end
        end
        checks++; if (o_fetch_cnt !== 16'd2 || o_data_cnt !== 16'd3) begin errors++;
            $display("FAIL reject_cnt got %0d/%0d want 2/3", o_fetch_cnt, o_data_cnt); end
    endtask

    task automatic test_reset_mid_store();
        i_ls_req = 1; i_ls_we = 1; i_ls_addr = 32'h20; i_ls_wdata = 32'h1234_5678;
        step();
        i_ls_req = 0;
        checks++; if (o_mem_we !== 1'b1) begin errors++; $display("FAIL midrst_we_before got %b want 1", o_mem_we); end
        i_rst = 1;
        #1;
        checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL midrst_we_async got %b want 0", o_mem_we); end
        checks++; if (o_fetch_cnt !== 16'd0 || o_data_cnt !== 16'd0 || o_instr !== 32'h0 ||
                      o_ldata !== 32'h0 || o_mem_addr !== 32'h0) begin errors++;
            $display("FAIL midrst_clear got fc=%0d dc=%0d instr=%h ld=%h addr=%h want all 0",
                     o_fetch_cnt, o_data_cnt, o_instr, o_ldata, o_mem_addr); end
        step();
        i_rst = 0;
        step();
        checks++; if (o_st_done !== 1'b0 || o_ready !== 1'b1 || o_data_cnt !== 16'd0) begin errors++;
            $display("FAIL midrst_after got done=%b rdy=%b dc=%0d want 0/1/0", o_st_done, o_ready, o_data_cnt); end
    endtask

    task automatic test_counter_wrap();
        int pulses = 0;
        if_req2 = 1; pc2 = 32'h0;
        for (int k = 0; k < 700 && pulses < 257; k++) begin
            step();
            if (instr_valid2) begin
                pulses++;
                if (pulses == 256) begin
                    checks++; if (fetch_cnt2 !== 8'd0) begin errors++;
                        $display("FAIL wrap_zero got %0d want 0", fetch_cnt2); end
                end
            end
        end
        if_req2 = 0;
        checks++; if (pulses != 257) begin errors++;
            $display("FAIL wrap_timeout got %0d fetches want 257", pulses); end
        checks++; if (fetch_cnt2 !== 8'd1 || instr2 !== 32'h1000_0000) begin errors++;
            $display("FAIL wrap_one got cnt=%0d instr=%h want 1/10000000", fetch_cnt2, instr2); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_load();
        test_priority();
        test_reject();
        test_reset_mid_store();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
